// File: rtl/pipe_skid_reg_pkg.sv
// riscv_pipe_pkg: shared constants and types for RISC-V inter-stage pipeline registers.
//   XLEN      - architectural word width
//   NOP_INSN  - canonical NOP (addi x0,x0,0), the usual idle value for instruction stages
//   OCC_W     - width of the skid register occupancy count (0..2)
//   skid_state_e - {main_v, skid_v} encoded occupancy states
package riscv_pipe_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam int OCC_W = 2;
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } skid_state_e;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: handshake bundle between producer stage, skid register and consumer stage.
//   flush                       - discard all held words
//   in_valid/in_ready/in_data   - producer side handshake
//   out_valid/out_ready/out_data- consumer side handshake
//   occupancy                   - held word count
//   master: drives the block (producer+consumer view); slave: the skid register itself.
interface pipe_skid_reg_if
   import riscv_pipe_pkg::*;
#(
   parameter int N = XLEN
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_data;
   logic [OCC_W-1:0] occupancy;
   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );
   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/pipe_skid_reg_slot.sv
// skid_slot: N-bit data register with async active-low reset, sync clear and load enable.
//   clk, rst_n - clock and async reset (reset value RSTVAL)
//   clr        - synchronous return to RSTVAL, dominates ld
//   ld, d      - load d on this edge
//   q          - registered value
module skid_slot #(
   parameter int          N      = 32,
   parameter logic [N-1:0] RSTVAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         ld,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   logic [N-1:0] data_d, data_q;
   always_comb data_d = clr ? RSTVAL : ld ? d : data_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) data_q <= RSTVAL;
      else        data_q <= data_d;
   assign q = data_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry main+skid elastic pipeline register with flush.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pipe_skid_reg_if.slave: flush, in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data, occupancy
// in_ready depends only on the registered skid-valid bit, so there is no
// combinational path from out_ready to in_ready.
module pipe_skid_reg
   import riscv_pipe_pkg::*;
#(
   parameter int           N      = XLEN,
   parameter logic [N-1:0] RSTVAL = '0
) (
   input logic             clk,
   input logic             rst_n,
   pipe_skid_reg_if.slave  bus
);
   skid_state_e  state_d, state_q;
   logic         main_v, skid_v;
   logic         in_xfer, out_xfer;
   logic         main_ld, skid_ld, main_from_skid;
   logic [N-1:0] main_q, skid_q, main_in;
   assign main_v   = state_q[1];
   assign skid_v   = state_q[0];
   assign in_xfer  = bus.in_valid & ~skid_v;
   assign out_xfer = main_v & bus.out_ready;
   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            state_d = in_xfer ? ONE : EMPTY;
            main_ld = in_xfer;
         end
         ONE: begin
            // simultaneous in/out keeps one word: the new word replaces main
            state_d = (in_xfer & ~out_xfer) ? FULL : (~in_xfer & out_xfer) ? EMPTY : ONE;
            main_ld = in_xfer & out_xfer;
            skid_ld = in_xfer & ~out_xfer;
         end
         FULL: begin
            state_d        = out_xfer ? ONE : FULL;
            main_ld        = out_xfer;
            main_from_skid = 1'b1;
         end
         default: state_d = EMPTY;
      endcase
      if (bus.flush) state_d = EMPTY;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   assign main_in = main_from_skid ? skid_q : bus.in_data;
   skid_slot #(.N(N), .RSTVAL(RSTVAL)) u_main (
      .clk(clk), .rst_n(rst_n), .clr(bus.flush), .ld(main_ld), .d(main_in), .q(main_q)
   );
   skid_slot #(.N(N), .RSTVAL(RSTVAL)) u_skid (
      .clk(clk), .rst_n(rst_n), .clr(bus.flush), .ld(skid_ld), .d(bus.in_data), .q(skid_q)
   );
   assign bus.in_ready  = ~skid_v;
   assign bus.out_valid = main_v;
   assign bus.out_data  = main_q;
   assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed self-checking bench for pipe_skid_reg.
module tb_pipe_skid_reg;
   import riscv_pipe_pkg::*;
   localparam logic [31:0] RV = NOP_INSN;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   pipe_skid_reg_if #(.N(32)) bus ();
   pipe_skid_reg #(.N(32), .RSTVAL(RV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic st(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
      chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ov});
      chk({tag, ".in_ready"},  {31'b0, bus.in_ready},  {31'b0, ir});
      chk({tag, ".occupancy"}, {30'b0, bus.occupancy}, {30'b0, occ});
   endtask
   task automatic drv(input logic v, input logic [31:0] d, input logic r, input logic f);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      bus.flush     = f;
   endtask
   initial begin
      drv(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      #12;
      st("rst", 1'b0, 1'b1, 2'd0);
      chk("rst.out_data", bus.out_data, RV);
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      st("idle", 1'b0, 1'b1, 2'd0);
      chk("idle.out_data", bus.out_data, RV);
      // streaming
      drv(1'b1, 32'h11, 1'b1, 1'b0); step();
      st("s11", 1'b1, 1'b1, 2'd1); chk("s11.data", bus.out_data, 32'h11);
      drv(1'b1, 32'h22, 1'b1, 1'b0); step();
      st("s22", 1'b1, 1'b1, 2'd1); chk("s22.data", bus.out_data, 32'h22);
      drv(1'b1, 32'h33, 1'b1, 1'b0); step();
      st("s33", 1'b1, 1'b1, 2'd1); chk("s33.data", bus.out_data, 32'h33);
      drv(1'b0, 32'h0, 1'b1, 1'b0); step();
      st("sdrain", 1'b0, 1'b1, 2'd0);
      // backpressure
      drv(1'b1, 32'hA1, 1'b0, 1'b0); step();
      st("bA1", 1'b1, 1'b1, 2'd1); chk("bA1.data", bus.out_data, 32'hA1);
      drv(1'b1, 32'hA2, 1'b0, 1'b0); step();
      st("bA2", 1'b1, 1'b0, 2'd2); chk("bA2.data", bus.out_data, 32'hA1);
      drv(1'b1, 32'hA3, 1'b0, 1'b0); step();
      st("bhold", 1'b1, 1'b0, 2'd2); chk("bhold.data", bus.out_data, 32'hA1);
      drv(1'b1, 32'hA3, 1'b1, 1'b0); step();
      st("bout1", 1'b1, 1'b1, 2'd1); chk("bout1.data", bus.out_data, 32'hA2);
      drv(1'b1, 32'hA3, 1'b1, 1'b0); step();
      st("bout2", 1'b1, 1'b1, 2'd1); chk("bout2.data", bus.out_data, 32'hA3);
      drv(1'b0, 32'h0, 1'b1, 1'b0); step();
      st("bdrain", 1'b0, 1'b1, 2'd0);
      // flush collision
      drv(1'b1, 32'hB1, 1'b0, 1'b0); step();
      drv(1'b1, 32'hB2, 1'b0, 1'b0); step();
      st("fB", 1'b1, 1'b0, 2'd2); chk("fB.data", bus.out_data, 32'hB1);
      drv(1'b1, 32'hB3, 1'b1, 1'b1); step();
      st("flush", 1'b0, 1'b1, 2'd0); chk("flush.data", bus.out_data, RV);
      drv(1'b0, 32'h0, 1'b1, 1'b0); step();
      st("postflush", 1'b0, 1'b1, 2'd0); chk("postflush.data", bus.out_data, RV);
      // async reset mid-stream
      drv(1'b1, 32'hC1, 1'b0, 1'b0); step();
      drv(1'b1, 32'hC2, 1'b0, 1'b0); step();
      st("aFull", 1'b1, 1'b0, 2'd2);
      drv(1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      st("arst", 1'b0, 1'b1, 2'd0); chk("arst.data", bus.out_data, RV);
      #1;
      rst_n = 1'b1;
      // recovery
      drv(1'b1, 32'hD1, 1'b1, 1'b0); step();
      st("rD1", 1'b1, 1'b1, 2'd1); chk("rD1.data", bus.out_data, 32'hD1);
      drv(1'b0, 32'h0, 1'b1, 1'b0); step();
      st("rdrain", 1'b0, 1'b1, 2'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
